// File: rtl/game_round_ctrl.sv
// Round sequencer for a timed game: IDLE -> COUNTDOWN -> PLAY -> OVER -> IDLE,
// driven by StartKey/TimeUp rising edges and a divided sequencing tick.
module game_round_ctrl #(
  parameter int unsigned TICK_DIV  = 50000000,
  parameter int unsigned CD_START  = 3,
  parameter int unsigned OVER_HOLD = 5
) (
  input  logic       ClockIn,
  input  logic       Reset,
  input  logic       StartKey,
  input  logic       TimeUp,
  output logic       GameRun,
  output logic       TimerClear,
  output logic [1:0] Countdown,
  output logic [2:0] State,
  output logic       RoundDone,
  output logic [3:0] RoundCount
);

  localparam int TICK_W = 27;
  localparam logic [TICK_W-1:0] TICK_RELOAD = TICK_W'(TICK_DIV - 1);
  localparam logic [1:0]        CD_INIT     = 2'(CD_START);
  localparam logic [3:0]        HOLD_INIT   = 4'(OVER_HOLD);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_PLAY      = 3'd2,
    S_OVER      = 3'd3
  } state_t;

  state_t              state_q, state_d;
  logic                key_prev_q, tu_prev_q;
  logic                key_edge, tu_edge;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic                in_timed, tick;
  logic [3:0]          hold_q, hold_d;
  logic [1:0]          countdown_q, countdown_d;
  logic                game_run_q, game_run_d;
  logic                timer_clear_q, timer_clear_d;
  logic                round_done_q, round_done_d;
  logic [3:0]          round_count_q, round_count_d;

  assign key_edge = StartKey & ~key_prev_q;
  assign tu_edge  = TimeUp & ~tu_prev_q;

  // The tick divider only runs while a timed state is active.
  assign in_timed = (state_q == S_COUNTDOWN) || (state_q == S_OVER);
  assign tick     = in_timed && (tick_cnt_q == '0);

  always_comb begin
    state_d       = state_q;
    countdown_d   = countdown_q;
    hold_d        = hold_q;
    round_count_d = round_count_q;
    timer_clear_d = 1'b0;
    round_done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        countdown_d = 2'd0;
        hold_d      = HOLD_INIT;
        if (key_edge) begin
          state_d       = S_COUNTDOWN;
          countdown_d   = CD_INIT;
          timer_clear_d = 1'b1;
        end
      end
      S_COUNTDOWN: begin
        if (tick) begin
          if (countdown_q <= 2'd1) begin
            state_d     = S_PLAY;
            countdown_d = 2'd0;
          end else begin
            countdown_d = countdown_q - 2'd1;
          end
        end
      end
      S_PLAY: begin
        countdown_d = 2'd0;
        hold_d      = HOLD_INIT;
        // Completion takes priority over an abort arriving in the same cycle.
        if (tu_edge) begin
          state_d      = S_OVER;
          round_done_d = 1'b1;
          if (round_count_q != 4'hF) begin
            round_count_d = round_count_q + 4'd1;
          end
        end else if (key_edge) begin
          state_d = S_IDLE;
        end
      end
      S_OVER: begin
        countdown_d = 2'd0;
        if (tick) begin
          if (hold_q <= 4'd1) begin
            state_d = S_IDLE;
            hold_d  = HOLD_INIT;
          end else begin
            hold_d = hold_q - 4'd1;
          end
        end
      end
      default: begin
        state_d     = S_IDLE;
        countdown_d = 2'd0;
        hold_d      = HOLD_INIT;
      end
    endcase

    game_run_d = (state_d == S_PLAY);

    // Reload on entry to a timed state and whenever the divider is idle.
    if (in_timed && (state_d == state_q)) begin
      tick_cnt_d = tick ? TICK_RELOAD : (tick_cnt_q - 1'b1);
    end else begin
      tick_cnt_d = TICK_RELOAD;
    end
  end

  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      state_q       <= S_IDLE;
      key_prev_q    <= 1'b1;
      tu_prev_q     <= 1'b1;
      tick_cnt_q    <= TICK_RELOAD;
      hold_q        <= HOLD_INIT;
      countdown_q   <= 2'd0;
      game_run_q    <= 1'b0;
      timer_clear_q <= 1'b0;
      round_done_q  <= 1'b0;
      round_count_q <= 4'd0;
    end else begin
      state_q       <= state_d;
      key_prev_q    <= StartKey;
      tu_prev_q     <= TimeUp;
      tick_cnt_q    <= tick_cnt_d;
      hold_q        <= hold_d;
      countdown_q   <= countdown_d;
      game_run_q    <= game_run_d;
      timer_clear_q <= timer_clear_d;
      round_done_q  <= round_done_d;
      round_count_q <= round_count_d;
    end
  end

  assign State      = state_q;
  assign Countdown  = countdown_q;
  assign GameRun    = game_run_q;
  assign TimerClear = timer_clear_q;
  assign RoundDone  = round_done_q;
  assign RoundCount = round_count_q;

endmodule
